// File: rtl/rocketcpu_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rocketcpu_wb_pkg
//  Purpose  : Shared Wishbone widths and arbiter state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package rocketcpu_wb_pkg;

    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY0 = 2'd1;
    localparam logic [1:0] ST_BUSY1 = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rocketcpu_uart_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rocketcpu_uart_arbiter_if
//  Purpose  : One Wishbone link. The initiator uses 'master', the target uses 'slave'.
//  Revision : 1.0  initial release
// ============================================================================
interface rocketcpu_uart_arbiter_if;
    import rocketcpu_wb_pkg::*;

    logic [WB_DW-1:0] dat;
    logic [WB_SW-1:0] sel;
    logic             we;
    logic             cyc;
    logic [WB_DW-1:0] rdt;
    logic             ack;
    logic             err;

    // The UART slave has no error line, so err is left out of the initiator view.
    modport master (output dat, sel, we, cyc, input rdt, ack);
    modport slave  (input dat, sel, we, cyc, output rdt, ack, err);

endinterface
`default_nettype wire

// File: rtl/rocketcpu_wb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : rocketcpu_wb_watchdog
//  Purpose  : Saturating bus-cycle counter that flags a hung slave access.
//  Revision : 1.0  initial release
// ============================================================================
module rocketcpu_wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  wire logic clk,
    input  wire logic resetn,
    input  wire logic clr,
    input  wire logic en,
    output logic      expired
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign expired = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/rocketcpu_uart_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rocketcpu_uart_arbiter
//  Purpose  : Round-robin two-master Wishbone arbiter in front of the UART slave.
//  Revision : 1.0  initial release
// ============================================================================
module rocketcpu_uart_arbiter
    import rocketcpu_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  wire logic                 i_wb_clk,
    input  wire logic                 resetn,
    rocketcpu_uart_arbiter_if.slave   m0,
    rocketcpu_uart_arbiter_if.slave   m1,
    rocketcpu_uart_arbiter_if.master  s,
    output logic [1:0]                o_grant
);

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       r_last;
    logic       w_last_next;
    logic       w_busy0;
    logic       w_busy1;
    logic       w_cyc;
    logic       w_expired;
    logic       w_done;

    // Gating with resetn drops slave cyc in the same cycle reset is asserted.
    assign w_busy0 = resetn && (r_state == ST_BUSY0);
    assign w_busy1 = resetn && (r_state == ST_BUSY1);
    assign w_cyc   = (w_busy0 && m0.cyc) || (w_busy1 && m1.cyc);
    assign w_done  = s.ack || !w_cyc || w_expired;

    always_comb begin
        w_next      = r_state;
        w_last_next = r_last;
        case (r_state)
            ST_IDLE: begin
                if (m0.cyc && (!m1.cyc || r_last)) begin
                    w_next = ST_BUSY0;
                end else if (m1.cyc) begin
                    w_next = ST_BUSY1;
                end
            end
            ST_BUSY0: begin
                if (w_done) begin
                    w_next      = ST_IDLE;
                    w_last_next = 1'b0;
                end
            end
            ST_BUSY1: begin
                if (w_done) begin
                    w_next      = ST_IDLE;
                    w_last_next = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_last  <= w_last_next;
        end
    end

    rocketcpu_wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk     (i_wb_clk),
        .resetn  (resetn),
        .clr     (r_state == ST_IDLE),
        .en      (w_busy0 || w_busy1),
        .expired (w_expired)
    );

    assign s.cyc = w_cyc;
    assign s.dat = w_busy0 ? m0.dat : (w_busy1 ? m1.dat : '0);
    assign s.sel = w_busy0 ? m0.sel : (w_busy1 ? m1.sel : '0);
    assign s.we  = (w_busy0 && m0.we) || (w_busy1 && m1.we);

    // An ack in the expiry cycle completes the access, so it suppresses err.
    assign m0.rdt = w_busy0 ? s.rdt : '0;
    assign m0.ack = w_busy0 && s.ack && m0.cyc;
    assign m0.err = w_busy0 && w_expired && !s.ack && m0.cyc;
    assign m1.rdt = w_busy1 ? s.rdt : '0;
    assign m1.ack = w_busy1 && s.ack && m1.cyc;
    assign m1.err = w_busy1 && w_expired && !s.ack && m1.cyc;

    assign o_grant = {w_busy1, w_busy0};

endmodule
`default_nettype wire
